// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: responder end of the dbus handshake. One request is served at a time
// from an internal 64-bit SRAM after a fixed LATENCY; data_ok is a one-cycle pulse.
//
// Handshake: in IDLE, addr_ok follows dreq.valid combinationally and the request is accepted
// in any cycle where valid is high (outside reset). The initiator keeps the fields stable until
// data_ok, which comes exactly LATENCY cycles after the accept. Dropping valid while busy does
// not cancel the response. A new request can be accepted in the cycle after data_ok at the
// earliest.

package dbus_sram_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

module dbus_sram_responder
    import dbus_sram_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err,
    output state_t     dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [63:0]      rdata;
    logic [63:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic [63:0]      offset;
    logic [63:0]      word_idx;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             unused_size;

    // Address decode: unsigned 64-bit offset from the base, so addresses below the base wrap
    // to a huge index and fall out of range instead of aliasing into the array.
    assign offset      = dreq.addr - BASE_ADDR;
    assign word_idx    = offset >> 3;
    assign in_range    = (dreq.addr >= BASE_ADDR) && (word_idx < 64'(DEPTH_WORDS));
    assign idx         = word_idx[IDX_W-1:0];
    assign unused_size = ^dreq.size;
    assign dbg_state   = state;

    // State register and latency counter; reset wins over any request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Next state: go busy on a valid request, return to idle after the response cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dreq.valid) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: addr_ok/accept in IDLE, data_ok with read data on the final busy cycle.
    always_comb begin
        accept = 1'b0;
        dresp  = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    dresp.addr_ok = dreq.valid;
                    accept        = dreq.valid;
                end
                BUSY: begin
                    dresp.data_ok = (cnt == 4'd0);
                    dresp.data    = (cnt == 4'd0) ? rdata : 64'd0;
                end
                default: begin
                    accept = 1'b0;
                end
            endcase
        end
    end

    // Byte-lane writes at the accept edge; the array is never cleared by reset.
    always_ff @(posedge clk) begin
        if (accept && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (dreq.strobe[b]) begin
                    mem[idx][8*b +: 8] <= dreq.data[8*b +: 8];
                end
            end
        end
    end

    // Read data captured at accept: pre-write word contents, or zero when out of range.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= 64'd0;
        end else if (accept) begin
            rdata <= in_range ? mem[idx] : 64'd0;
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (accept && !in_range) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances (LATENCY 2, 1, 15) checked every cycle
// against a time-based transaction model, plus literal expectations for the directed cases.
`timescale 1ns/1ps
module tb_dbus_sram_responder;
  import dbus_sram_pkg::*;

  localparam int NI = 3;
  localparam int DEPTH = 1024;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int WIN = 16;
  localparam int LAT [NI] = '{2, 1, 15};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dbus_req_t  req  [NI];
  dbus_resp_t resp [NI];
  logic       err  [NI];
  state_t     dbg  [NI];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(reset), .dreq(req[0]), .dresp(resp[0]), .err(err[0]), .dbg_state(dbg[0]));
  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(reset), .dreq(req[1]), .dresp(resp[1]), .err(err[1]), .dbg_state(dbg[1]));
  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15), .BASE_ADDR(BASE)) dut2 (
    .clk(clk), .reset(reset), .dreq(req[2]), .dresp(resp[2]), .err(err[2]), .dbg_state(dbg[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction per instance, described by the cycle its response is due.
  bit          m_busy   [NI];
  int          m_due    [NI];
  logic [63:0] m_rdata  [NI];
  bit          m_rknown [NI];
  bit          m_err    [NI];
  logic [63:0] m_mem    [NI][WIN];
  bit          m_known  [NI][WIN];

  task automatic model_access(input int i);
    logic [63:0] a;
    logic [63:0] w;
    a = req[i].addr;
    w = (a - BASE) >> 3;
    if (a >= BASE && w < 64'(DEPTH)) begin
      if (w < 64'(WIN)) begin
        m_rdata[i]  = m_mem[i][w];
        m_rknown[i] = m_known[i][w];
        for (int b = 0; b < 8; b++)
          if (req[i].strobe[b]) m_mem[i][w][8*b +: 8] = req[i].data[8*b +: 8];
        if (req[i].strobe == 8'hFF) m_known[i][w] = 1'b1;
      end else begin
        m_rknown[i] = 1'b0;
      end
    end else begin
      m_rdata[i]  = 64'd0;
      m_rknown[i] = 1'b1;
      m_err[i]    = 1'b1;
    end
  endtask

  // ---------------- scoreboard: compare every cycle, then advance the model ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic exp_aok;
      logic exp_dok;
      exp_aok = reset && !m_busy[i] && req[i].valid;
      exp_dok = reset && m_busy[i] && (cyc == m_due[i]);
      check($sformatf("addr_ok[%0d]", i), 64'(resp[i].addr_ok), 64'(exp_aok));
      check($sformatf("data_ok[%0d]", i), 64'(resp[i].data_ok), 64'(exp_dok));
      check($sformatf("err[%0d]", i), 64'(err[i]), 64'(m_err[i]));
      if (!exp_dok)
        check($sformatf("idle_data[%0d]", i), resp[i].data, 64'd0);
      else if (m_rknown[i])
        check($sformatf("rdata[%0d]", i), resp[i].data, m_rdata[i]);
      if (!reset) begin
        m_busy[i] = 1'b0;
        m_err[i]  = 1'b0;
      end else if (exp_aok) begin
        model_access(i);
        m_busy[i] = 1'b1;
        m_due[i]  = cyc + LAT[i];
      end else if (exp_dok) begin
        m_busy[i] = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  function automatic dbus_req_t mk_req(input logic v, input logic [63:0] a,
                                       input logic [7:0] s, input logic [63:0] d);
    dbus_req_t r;
    r.valid  = v;
    r.addr   = a;
    r.size   = 3'($urandom_range(0, 7));
    r.strobe = s;
    r.data   = d;
    return r;
  endfunction

  // Full transaction on instance 0; returns response data and measured accept-to-data_ok cycles.
  task automatic xact(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                      input bit drop, output logic [63:0] rd, output int lat);
    bit got;
    req[0] = mk_req(1'b1, a, s, d);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = resp[0].addr_ok;
      @(posedge clk);
      #1;
    end
    check("accept_wait", 64'(got), 64'd1);
    if (drop) req[0].valid = 1'b0;
    got = 0;
    rd = '0;
    lat = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (resp[0].data_ok) begin
        got = 1;
        rd = resp[0].data;
        lat = n + 1;
      end
      @(posedge clk);
      #1;
    end
    check("data_ok_wait", 64'(got), 64'd1);
    req[0] = mk_req(1'b0, {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom});
  endtask

  // Valid held continuously; fields change only right after each response.
  task automatic held_run(input int i, input int n);
    int since;
    bit got;
    req[i] = mk_req(1'b1, BASE, 8'hFF, {$urandom, $urandom});
    since = 0;
    for (int k = 0; k < n; k++) begin
      got = 0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        since++;
        if (resp[i].data_ok) got = 1;
        @(posedge clk);
        #1;
      end
      check($sformatf("held_data_ok_wait[%0d]", i), 64'(got), 64'd1);
      if (k > 0) check($sformatf("held_period[%0d]", i), 64'(since), 64'(LAT[i] + 1));
      since = 0;
      req[i] = mk_req(1'b1, BASE + 64'((k + 1) % 4) * 8, 8'hFF, {$urandom, $urandom});
    end
    req[i].valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rd;
    logic [63:0] a;
    logic [7:0]  s;
    int          lat;
    int          sel;
    for (int i = 0; i < NI; i++) req[i] = '0;

    // Reset with a request pending: nothing may be accepted during reset.
    req[0] = mk_req(1'b1, BASE, 8'h00, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    req[0] = '0;
    reset = 1'b1;
    @(negedge clk);
    check("reset_state", 64'(dbg[0]), 64'(IDLE));
    check("reset_err", 64'(err[0]), 64'd0);
    @(posedge clk);
    #1;

    // Held-valid throughput on LATENCY 1 and 15.
    fork
      held_run(1, 12);
      held_run(2, 6);
    join

    // Preload the test window of instance 0 with zeros.
    for (int w = 0; w < WIN; w++) xact(BASE + 64'(w) * 8, 8'hFF, 64'd0, 1'b0, rd, lat);

    // Read at the base: zero data, LATENCY 2.
    xact(BASE, 8'h00, 64'd0, 1'b0, rd, lat);
    check("base_read_data", rd, 64'd0);
    check("base_read_latency", 64'(lat), 64'd2);

    // Full write, byte-0 write, read back merged word.
    xact(BASE + 8, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, rd, lat);
    check("wr1_prev", rd, 64'd0);
    xact(BASE + 8, 8'h01, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, rd, lat);
    check("wr2_prev", rd, 64'h1122_3344_5566_7788);
    xact(BASE + 8, 8'h00, 64'd0, 1'b0, rd, lat);
    check("merged_read", rd, 64'h1122_3344_5566_77AA);

    // Out-of-range on both sides, including a write that must not land anywhere.
    xact(BASE - 8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, rd, lat);
    check("below_base_data", rd, 64'd0);
    @(negedge clk);
    check("below_base_err", 64'(err[0]), 64'd1);
    @(posedge clk);
    #1;
    xact(BASE + 64'(DEPTH) * 8, 8'h00, 64'd0, 1'b0, rd, lat);
    check("above_top_data", rd, 64'd0);
    check("err_sticky", 64'(err[0]), 64'd1);
    xact(BASE + 8, 8'h00, 64'd0, 1'b0, rd, lat);
    check("array_unchanged", rd, 64'h1122_3344_5566_77AA);

    // Reset while busy with the counter still running.
    req[0] = mk_req(1'b1, BASE + 8, 8'h00, 64'd0);
    sel = 0;
    for (int n = 0; n < 40 && sel == 0; n++) begin
      @(negedge clk);
      if (resp[0].addr_ok) sel = 1;
      @(posedge clk);
      #1;
    end
    check("busy_reset_accept", 64'(sel), 64'd1);
    reset = 1'b0;
    req[0].valid = 1'b0;
    @(negedge clk);
    check("busy_reset_no_data_ok", 64'(resp[0].data_ok), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("busy_reset_idle", 64'(dbg[0]), 64'(IDLE));
    check("busy_reset_err_clear", 64'(err[0]), 64'd0);
    check("busy_reset_no_late_ok", 64'(resp[0].data_ok), 64'd0);
    @(posedge clk);
    #1;
    xact(BASE + 8, 8'h00, 64'd0, 1'b0, rd, lat);
    check("after_reset_read", rd, 64'h1122_3344_5566_77AA);

    // Valid dropped right after accept: response still arrives on time.
    xact(BASE + 8, 8'h00, 64'd0, 1'b1, rd, lat);
    check("drop_latency", 64'(lat), 64'd2);
    check("drop_data", rd, 64'h1122_3344_5566_77AA);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 85) begin
        a = BASE + 64'($urandom_range(0, WIN - 1)) * 8 + 64'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 3))
          0: a = BASE - 64'($urandom_range(1, 64));
          1: a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 4096));
          2: a = 64'($urandom_range(0, 255));
          default: a = 64'hFFFF_FFFF_FFFF_FFF8;
        endcase
      end
      s = ($urandom_range(0, 99) < 30) ? 8'h00 : 8'($urandom_range(1, 255));
      xact(a, s, {$urandom, $urandom}, ($urandom_range(0, 3) == 0), rd, lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
